// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: buffers {pc, instr} so fetch can run ahead of a stalled decode.
// Pushed entries appear on out_* the cycle after the push edge; in_ready is state-only so it can drive the PC register WE.
module if_id_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc8,
  output logic [31:0]              out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // in_ready depends only on count, so a pop cannot free a slot for a same-cycle push.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = 32'h0;
    if (out_valid) begin
      out_pc    = mem[rd_ptr].pc;
      out_instr = mem[rd_ptr].instr;
    end
  end

  assign out_pc8 = out_pc + 32'd8;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue with DEPTH=4 and RESET_PC=0x3000.
module tb_if_id_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
  logic [31:0] out_instr;
  logic        flush;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  if_id_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc8(out_pc8),
    .out_instr(out_instr), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ovld"},  32'(out_valid), 32'd0);
    chk({tag, "_pc"},    out_pc, 32'h0000_3000);
    chk({tag, "_pc8"},   out_pc8, 32'h0000_3008);
    chk({tag, "_instr"}, out_instr, 32'h0);
  endtask

  logic [31:0] got [$];
  int          sent;
  int          cyc;

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk_empty("reset");
    chk("reset_irdy", 32'(in_ready), 32'd1);
    tick(); tick();
    reset = 1'b1;

    // Streaming: every push is visible after its edge, count never exceeds 1.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_3000, 32'h2401_0001);
    #1;
    chk("nobypass_ovld", 32'(out_valid), 32'd0);
    tick();
    chk("s0_pc", out_pc, 32'h0000_3000);
    chk("s0_instr", out_instr, 32'h2401_0001);
    chk("s0_pc8", out_pc8, 32'h0000_3008);
    chk("s0_count", 32'(count), 32'd1);
    drive(1'b1, 32'h0000_3004, 32'h2402_0002);
    tick();
    chk("s1_pc", out_pc, 32'h0000_3004);
    chk("s1_instr", out_instr, 32'h2402_0002);
    chk("s1_count", 32'(count), 32'd1);
    chk("s1_irdy", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0000_3008, 32'h0022_1821);
    tick();
    chk("s2_pc", out_pc, 32'h0000_3008);
    chk("s2_instr", out_instr, 32'h0022_1821);
    chk("s2_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("s_drain");

    // Fill to full with decode stalled; the fifth push must be dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 32'h2400_0000 + 32'(i));
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_irdy", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h0000_3010, 32'h2400_0004);
    tick();
    chk("full5_count", 32'(count), 32'd4);
    chk("full5_head", out_pc, 32'h0000_3000);
    chk("full5_instr", out_instr, 32'h2400_0000);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("pop1_head", out_pc, 32'h0000_3004);
    tick();
    chk("pop2_head", out_pc, 32'h0000_3008);
    tick();
    chk("pop3_head", out_pc, 32'h0000_300C);
    chk("pop3_instr", out_instr, 32'h2400_0003);
    tick();
    chk_empty("pop4");

    // Full with simultaneous pop: no push that edge, push+pop the next.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 32'h2400_0000 + 32'(i));
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_3010, 32'h2400_0004);
    tick();
    chk("fp1_count", 32'(count), 32'd3);
    chk("fp1_head", out_pc, 32'h0000_3004);
    chk("fp1_irdy", 32'(in_ready), 32'd1);
    tick();
    chk("fp2_count", 32'(count), 32'd3);
    chk("fp2_head", out_pc, 32'h0000_3008);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("fp3_head", out_pc, 32'h0000_300C);
    tick();
    chk("fp4_head", out_pc, 32'h0000_3010);
    chk("fp4_instr", out_instr, 32'h2400_0004);
    tick();
    chk_empty("fp_drain");

    // Wrap-around: fetch holds its PC until accepted, decode ready toggles.
    got.delete();
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || out_valid) && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      if (sent < 10) drive(1'b1, 32'h0000_3000 + 32'(4 * sent), 32'h2400_0100 + 32'(sent));
      else           drive(1'b0, 32'h0, 32'h0);
      #1;
      if (out_valid && out_ready) got.push_back(out_pc);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b0;
    chk("wrap_sent", 32'(sent), 32'd10);
    chk("wrap_ngot", 32'(got.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < got.size()) chk($sformatf("wrap_pc%0d", k), got[k], 32'h0000_3000 + 32'(4 * k));
    end
    chk_empty("wrap_end");

    // Flush drops stored entries and the in-flight fetch.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_5000 + 32'(4 * i), 32'h2400_0200 + 32'(i));
      tick();
    end
    chk("fl_pre_count", 32'(count), 32'd3);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h0000_3100, 32'h2400_0300);
    #1;
    chk("fl_irdy", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk_empty("fl_after");
    tick();
    chk("fl_still_empty", 32'(count), 32'd0);
    drive(1'b1, 32'h0000_4000, 32'h2400_0400);
    tick();
    chk("fl_new_head", out_pc, 32'h0000_4000);
    chk("fl_new_instr", out_instr, 32'h2400_0400);
    chk("fl_new_pc8", out_pc8, 32'h0000_4008);

    // pc8 carry is discarded at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 32'h2400_0500);
    tick();
    chk("wrap8_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap8_pc8", out_pc8, 32'h0000_0004);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk_empty("wrap8_drain");

    // Asynchronous reset mid-run with three entries stored.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_6000 + 32'(4 * i), 32'h2400_0600 + 32'(i));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_pre_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_empty("ar_now");
    chk("ar_irdy", 32'(in_ready), 32'd1);
    #2;
    reset = 1'b1;
    tick();
    chk_empty("ar_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
